// File: rtl/ps2_key_matrix_if.sv
// Keyboard-side bundle: PS/2 lines and CPU row address in, column reply and
// host function levels out.
interface ps2_key_matrix_if;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [15:0] a;
    logic [4:0]  keyb;
    logic        f1;
    logic        f11;

    modport master (output ps2_clk, ps2_dat, a, input keyb, f1, f11);
    modport slave  (input ps2_clk, ps2_dat, a, output keyb, f1, f11);
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 receiver feeding the Spectrum 8x5 key matrix; the column reply
// is combinational from A[15:8].
module ps2_key_matrix #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 14000
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_key_matrix_if.slave bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // index 0 = PS/2 clock, index 1 = PS/2 data
    logic [1:0]         s1, s2, filt;
    logic [1:0][FW-1:0] fcnt;
    logic               clk_d;
    logic               fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            filt  <= 2'b11;
            fcnt  <= '0;
            clk_d <= 1'b1;
        end else begin
            s1    <= {bus.ps2_dat, bus.ps2_clk};
            s2    <= s1;
            clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_d & ~filt[0];

    // sr collects start, D0..D7, parity; the stop bit is judged live
    logic [3:0]    bit_cnt;
    logic [9:0]    sr;
    logic [TW-1:0] tmo;
    logic          byte_vld;
    logic [7:0]    byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            sr       <= '0;
            tmo      <= '0;
            byte_vld <= 1'b0;
            byte_q   <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (fall) begin
                tmo <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!sr[0] && (^sr[9:1]) && filt[1]) begin
                        byte_q   <= sr[8:1];
                        byte_vld <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    sr      <= {filt[1], sr[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (tmo == TW'(TIMEOUT - 1)) begin
                    bit_cnt <= '0;
                    tmo     <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

    // {hit, row, bit} for keys that own exactly one matrix position
    function automatic logic [6:0] lookup(input logic [7:0] c);
        case (c)
            8'h1A: return {1'b1, 3'd0, 3'd1};
            8'h22: return {1'b1, 3'd0, 3'd2};
            8'h21: return {1'b1, 3'd0, 3'd3};
            8'h2A: return {1'b1, 3'd0, 3'd4};
            8'h1C: return {1'b1, 3'd1, 3'd0};
            8'h1B: return {1'b1, 3'd1, 3'd1};
            8'h23: return {1'b1, 3'd1, 3'd2};
            8'h2B: return {1'b1, 3'd1, 3'd3};
            8'h34: return {1'b1, 3'd1, 3'd4};
            8'h15: return {1'b1, 3'd2, 3'd0};
            8'h1D: return {1'b1, 3'd2, 3'd1};
            8'h24: return {1'b1, 3'd2, 3'd2};
            8'h2D: return {1'b1, 3'd2, 3'd3};
            8'h2C: return {1'b1, 3'd2, 3'd4};
            8'h16: return {1'b1, 3'd3, 3'd0};
            8'h1E: return {1'b1, 3'd3, 3'd1};
            8'h26: return {1'b1, 3'd3, 3'd2};
            8'h25: return {1'b1, 3'd3, 3'd3};
            8'h2E: return {1'b1, 3'd3, 3'd4};
            8'h45: return {1'b1, 3'd4, 3'd0};
            8'h46: return {1'b1, 3'd4, 3'd1};
            8'h3E: return {1'b1, 3'd4, 3'd2};
            8'h3D: return {1'b1, 3'd4, 3'd3};
            8'h36: return {1'b1, 3'd4, 3'd4};
            8'h4D: return {1'b1, 3'd5, 3'd0};
            8'h44: return {1'b1, 3'd5, 3'd1};
            8'h43: return {1'b1, 3'd5, 3'd2};
            8'h3C: return {1'b1, 3'd5, 3'd3};
            8'h35: return {1'b1, 3'd5, 3'd4};
            8'h5A: return {1'b1, 3'd6, 3'd0};
            8'h4B: return {1'b1, 3'd6, 3'd1};
            8'h42: return {1'b1, 3'd6, 3'd2};
            8'h3B: return {1'b1, 3'd6, 3'd3};
            8'h33: return {1'b1, 3'd6, 3'd4};
            8'h29: return {1'b1, 3'd7, 3'd0};
            8'h14: return {1'b1, 3'd7, 3'd1};
            8'h3A: return {1'b1, 3'd7, 3'd2};
            8'h31: return {1'b1, 3'd7, 3'd3};
            8'h32: return {1'b1, 3'd7, 3'd4};
            default: return '0;
        endcase
    endfunction

    // shifts and backspace are held apart so overlapping CS sources release cleanly
    logic [7:0][4:0] mat;
    logic            rel, ext, lsh, rsh, bksp, f1_q, f11_q;
    logic [6:0]      lk;

    assign lk = lookup(byte_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat   <= '0;
            rel   <= 1'b0;
            ext   <= 1'b0;
            lsh   <= 1'b0;
            rsh   <= 1'b0;
            bksp  <= 1'b0;
            f1_q  <= 1'b0;
            f11_q <= 1'b0;
        end else if (byte_vld) begin
            if (byte_q == 8'hF0) begin
                rel <= 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext <= 1'b1;
            end else begin
                rel <= 1'b0;
                ext <= 1'b0;
                if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                    mat   <= '0;
                    lsh   <= 1'b0;
                    rsh   <= 1'b0;
                    bksp  <= 1'b0;
                    f1_q  <= 1'b0;
                    f11_q <= 1'b0;
                end else if (byte_q == 8'hAA || byte_q == 8'hFA) begin
                    mat <= mat;
                end else if (ext) begin
                    if (byte_q == 8'h5A) mat[6][0] <= ~rel;
                    if (byte_q == 8'h14) mat[7][1] <= ~rel;
                end else begin
                    case (byte_q)
                        8'h12:   lsh   <= ~rel;
                        8'h59:   rsh   <= ~rel;
                        8'h66:   bksp  <= ~rel;
                        8'h05:   f1_q  <= ~rel;
                        8'h78:   f11_q <= ~rel;
                        default: if (lk[6]) mat[lk[5:3]][lk[2:0]] <= ~rel;
                    endcase
                end
            end
        end
    end

    logic [7:0][4:0] pressed;
    logic [4:0]      hit;
    logic            unused_a;

    always_comb begin
        pressed       = mat;
        pressed[0][0] = mat[0][0] | lsh | rsh | bksp;
        pressed[4][0] = mat[4][0] | bksp;
        hit           = '0;
        for (int r = 0; r < 8; r++)
            hit = hit | (pressed[r] & {5{~bus.a[8+r]}});
    end

    assign bus.keyb = ~hit;
    assign bus.f1   = f1_q;
    assign bus.f11  = f11_q;
    assign unused_a = ^bus.a[7:0];
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed PS/2 frame sequence; expected replies are queued per step and
// compared when popped.
module tb_ps2_key_matrix;
    localparam int HALF = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ps2_key_matrix_if bus ();

    ps2_key_matrix #(.FILTER(8), .TIMEOUT(14000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [4:0]  keyb;
        logic        f1;
        logic        f11;
    } exp_t;

    exp_t exp_q[$];

    task automatic send_frame(input logic [7:0] d, input bit bad_par = 1'b0, input int nbits = 11);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_dat = f[i];
            #(HALF);
            bus.ps2_clk = 1'b0;
            #(HALF);
            bus.ps2_clk = 1'b1;
        end
        #(HALF);
        bus.ps2_dat = 1'b1;
        #(2 * HALF);
    endtask

    task automatic check_next();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        bus.a = e.a;
        @(negedge clk);
        assert ({bus.keyb, bus.f1, bus.f11} === {e.keyb, e.f1, e.f11}) else begin
            errors++;
            $error("FAIL %s: got keyb=%h f1=%b f11=%b, expected keyb=%h f1=%b f11=%b",
                   e.tag, bus.keyb, bus.f1, bus.f11, e.keyb, e.f1, e.f11);
        end
    endtask

    task automatic expect_chk(input string tag, input logic [15:0] a, input logic [4:0] k,
                              input logic f1, input logic f11);
        exp_t e;
        e.tag = tag; e.a = a; e.keyb = k; e.f1 = f1; e.f11 = f11;
        exp_q.push_back(e);
        check_next();
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        bus.a       = 16'hFFFE;
        #103;
        expect_chk("reset_none",  16'hFFFE, 5'h1F, 1'b0, 1'b0);
        expect_chk("reset_all",   16'h00FE, 5'h1F, 1'b0, 1'b0);
        rst_n = 1'b1;
        #(4 * HALF);

        // 1: single letter press/release
        send_frame(8'h1C);
        expect_chk("a_press",     16'hFDFE, 5'h1E, 1'b0, 1'b0);
        send_frame(8'hF0); send_frame(8'h1C);
        expect_chk("a_release",   16'hFDFE, 5'h1F, 1'b0, 1'b0);

        // 2: shift + Z share row 0
        send_frame(8'h12); send_frame(8'h1A);
        expect_chk("cs_z",        16'hFEFE, 5'h1C, 1'b0, 1'b0);
        send_frame(8'hF0); send_frame(8'h12);
        expect_chk("z_only",      16'hFEFE, 5'h1D, 1'b0, 1'b0);

        // 3: two rows selected at once
        send_frame(8'h1C); send_frame(8'h15);
        expect_chk("rows12",      16'hF9FE, 5'h1E, 1'b0, 1'b0);
        expect_chk("no_row",      16'hFFFE, 5'h1F, 1'b0, 1'b0);
        expect_chk("row2",        16'hFBFE, 5'h1E, 1'b0, 1'b0);
        send_frame(8'h1B); send_frame(8'hF0); send_frame(8'h1B);
        expect_chk("s_tap",       16'hFDFE, 5'h1E, 1'b0, 1'b0);

        // 4: framing errors and timeout
        send_frame(8'hFF);
        expect_chk("overflow_clr",16'h00FE, 5'h1F, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1);
        expect_chk("bad_parity",  16'hFDFE, 5'h1F, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 6);
        #(15000 * 10);
        send_frame(8'h29);
        expect_chk("after_tmo",   16'h7FFE, 5'h1E, 1'b0, 1'b0);
        expect_chk("partial_drop",16'hFDFE, 5'h1F, 1'b0, 1'b0);

        // 5: function keys, ignored extended shift, overflow clear
        send_frame(8'h05);
        expect_chk("f1_on",       16'hFFFE, 5'h1F, 1'b1, 1'b0);
        send_frame(8'hE0); send_frame(8'h12);
        expect_chk("e0_12_ign",   16'hFEFE, 5'h1F, 1'b1, 1'b0);
        send_frame(8'h78);
        expect_chk("f11_on",      16'hFFFE, 5'h1F, 1'b1, 1'b1);
        send_frame(8'hE0); send_frame(8'h5A);
        expect_chk("kp_enter",    16'hBFFE, 5'h1E, 1'b1, 1'b1);
        send_frame(8'hFF);
        expect_chk("ff_clear",    16'h00FE, 5'h1F, 1'b0, 1'b0);

        // 6: reset mid-frame with backspace held
        send_frame(8'h05); send_frame(8'h66);
        expect_chk("bksp_cs",     16'hFEFE, 5'h1E, 1'b1, 1'b0);
        expect_chk("bksp_0",      16'hEFFE, 5'h1E, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 5);
        rst_n = 1'b0;
        #3;
        expect_chk("rst_mid",     16'h00FE, 5'h1F, 1'b0, 1'b0);
        #50;
        rst_n = 1'b1;
        #(4 * HALF);
        send_frame(8'h1C);
        expect_chk("post_rst_a",  16'hFDFE, 5'h1E, 1'b0, 1'b0);
        expect_chk("post_rst_cs", 16'hEEFE, 5'h1F, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
